// File: rtl/vclk_mode_seq.sv
// ============================================================================
// Module   : vclk_mode_seq
// Brief    : Glitch-free video clock source switch sequencer (28.63636MHz / PLL 25.175MHz).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vclk_mode_seq #(
   parameter int PRE_CYCLES   = 16,
   parameter int POST_CYCLES  = 64,
   parameter int LOCK_TIMEOUT = 1048575,
   parameter int VBL_TIMEOUT  = 600000
) (
   input  logic clk,
   input  logic reset,
   input  logic mode_req,
   input  logic vblank,
   input  logic pll_locked,
   input  logic err_clr,
   output logic video_mode,
   output logic video_rst,
   output logic busy,
   output logic lock_err
);

   localparam logic [19:0] c_cnt_max   = 20'hFFFFF;
   localparam logic [19:0] c_pre_last  = 20'(PRE_CYCLES - 1);
   localparam logic [19:0] c_post_last = 20'(POST_CYCLES - 1);
   localparam logic [19:0] c_lock_last = 20'(LOCK_TIMEOUT - 1);
   localparam logic [19:0] c_vbl_last  = 20'(VBL_TIMEOUT - 1);
   localparam logic [19:0] c_lock_min  = 20'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_VBL  = 3'd1,
      S_PRE       = 3'd2,
      S_WAIT_LOCK = 3'd3,
      S_SETTLE    = 3'd4
   } state_t;

   state_t      r_state, w_state_nx;
   logic [19:0] r_cnt, w_cnt_nx;
   logic        r_video_mode, w_video_mode_nx;
   logic        r_video_rst, w_video_rst_nx;
   logic        r_lock_err, w_lock_err_nx;
   logic        r_tgt, w_tgt_nx;

   logic        r_vbl_m, r_vblank_s, r_vblank_s_d;
   logic        r_lock_m, r_lock_s;
   logic        w_vbl_rise;
   logic        w_eff_req;

   // Two-flop synchronisers for the vclk-domain vblank and the async PLL lock
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vbl_m      <= 1'b0;
         r_vblank_s   <= 1'b0;
         r_vblank_s_d <= 1'b0;
         r_lock_m     <= 1'b0;
         r_lock_s     <= 1'b0;
      end else begin
         r_vbl_m      <= vblank;
         r_vblank_s   <= r_vbl_m;
         r_vblank_s_d <= r_vblank_s;
         r_lock_m     <= pll_locked;
         r_lock_s     <= r_lock_m;
      end
   end

   assign w_vbl_rise = r_vblank_s & ~r_vblank_s_d;
   assign w_eff_req  = mode_req & ~r_lock_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_SETTLE;
         r_cnt        <= 20'd0;
         r_video_mode <= 1'b0;
         r_video_rst  <= 1'b1;
         r_lock_err   <= 1'b0;
         r_tgt        <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_video_mode <= w_video_mode_nx;
         r_video_rst  <= w_video_rst_nx;
         r_lock_err   <= w_lock_err_nx;
         r_tgt        <= w_tgt_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_cnt_nx        = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 20'd1;
      w_video_mode_nx = r_video_mode;
      w_video_rst_nx  = r_video_rst;
      w_tgt_nx        = r_tgt;
      w_lock_err_nx   = err_clr ? 1'b0 : r_lock_err;

      case (r_state)
         S_IDLE: begin
            if (w_eff_req != r_video_mode) begin
               w_tgt_nx   = w_eff_req;
               w_cnt_nx   = 20'd0;
               w_state_nx = S_WAIT_VBL;
            end
         end
         S_WAIT_VBL: begin
            // A withdrawn request leaves without ever touching video_rst
            if (w_eff_req == r_video_mode) begin
               w_state_nx = S_IDLE;
            end else if (w_vbl_rise || (r_cnt == c_vbl_last)) begin
               w_video_rst_nx = 1'b1;
               w_cnt_nx       = 20'd0;
               w_state_nx     = S_PRE;
            end
         end
         S_PRE: begin
            if (r_cnt == c_pre_last) begin
               w_video_mode_nx = r_tgt;
               w_cnt_nx        = 20'd0;
               w_state_nx      = r_tgt ? S_WAIT_LOCK : S_SETTLE;
            end
         end
         S_WAIT_LOCK: begin
            // Minimum dwell lets the lock synchroniser flush stale samples
            if ((r_cnt >= c_lock_min) && r_lock_s) begin
               w_cnt_nx   = 20'd0;
               w_state_nx = S_SETTLE;
            end else if (r_cnt == c_lock_last) begin
               w_video_mode_nx = 1'b0;
               w_lock_err_nx   = 1'b1;
               w_cnt_nx        = 20'd0;
               w_state_nx      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == c_post_last) begin
               w_video_rst_nx = 1'b0;
               w_state_nx     = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_SETTLE;
            w_cnt_nx   = 20'd0;
         end
      endcase
   end

   assign video_mode = r_video_mode;
   assign video_rst  = r_video_rst;
   assign lock_err   = r_lock_err;
   assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
